// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction memory fetch block.
package imem_pkg;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_MISALIGN,
        ERR_RANGE
    } err_e;

    localparam int MAX_DATA_W = 256;
    localparam logic [MAX_DATA_W-1:0] NOP = '0;

    // Misalignment wins over range so a bad low-order address is reported as such.
    function automatic err_e classify(input logic [31:0] addr,
                                      input int unsigned sh,
                                      input int unsigned depth);
        logic [31:0] mask;
        mask = (32'd1 << sh) - 32'd1;
        if ((addr & mask) != '0)
            return ERR_MISALIGN;
        if ((addr >> sh) >= depth)
            return ERR_RANGE;
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: synchronous write, combinational read, no reset.
module imem_array import imem_pkg::*; #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Guard only matters for non-power-of-two depths.
    always_ff @(posedge clk) begin
        if (we && (32'(waddr) < DEPTH))
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_fetch.sv
// Instruction fetch: address checks, load forwarding, one-deep registered
// response with valid/ready back-pressure.
module imem_fetch import imem_pkg::*; #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_instr,
    output logic [ADDR_W-1:0]        rsp_addr,
    output logic                     rsp_err,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [DATA_W-1:0]        ld_data
);

    localparam int BYTE_SH = $clog2(DATA_W / 8);
    localparam int IDX_W   = $clog2(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] addr;
        logic              err;
    } rsp_t;

    err_e              req_err;
    logic              err_any;
    logic [31:0]       widx;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] fwd_data;
    logic              accept;
    logic              vld_q;
    rsp_t              rsp_q;

    assign req_err = classify(32'(req_addr), BYTE_SH, DEPTH);
    assign err_any = (req_err != ERR_NONE);
    assign widx    = 32'(req_addr) >> BYTE_SH;

    imem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (ld_en),
        .waddr (ld_addr),
        .wdata (ld_data),
        .raddr (widx[IDX_W-1:0]),
        .rdata (rd_data)
    );

    // A load landing on the word being fetched this cycle is returned directly.
    always_comb begin
        fwd_data = rd_data;
        if (ld_en && (32'(ld_addr) == widx))
            fwd_data = ld_data;
    end

    assign req_ready = !vld_q || rsp_ready;
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            rsp_q <= '0;
        end else if (accept) begin
            vld_q       <= 1'b1;
            rsp_q.instr <= err_any ? NOP[DATA_W-1:0] : fwd_data;
            rsp_q.addr  <= req_addr;
            rsp_q.err   <= err_any;
        end else if (rsp_ready) begin
            vld_q <= 1'b0;
        end
    end

    assign rsp_valid = vld_q;
    assign rsp_instr = rsp_q.instr;
    assign rsp_addr  = rsp_q.addr;
    assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_imem_fetch.sv
// Table-driven fetch vectors with a response scoreboard, plus stall,
// forwarding and asynchronous-reset sequences.
module tb_imem_fetch;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 9;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_instr;
    logic [ADDR_W-1:0] rsp_addr;
    logic              rsp_err;
    logic              ld_en;
    logic [5:0]        ld_addr;
    logic [DATA_W-1:0] ld_data;

    imem_fetch #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_addr  (rsp_addr),
        .rsp_err   (rsp_err),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] instr;
        logic              err;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] instr;
        logic              err;
        int                acc_cyc;
        bit                lat;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t sb[$];
    vec_t vecs[8];

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: a response is taken whenever valid and ready meet.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", {rsp_addr, rsp_instr, rsp_err}, 64'hx);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk($sformatf("rsp addr=%0d {addr,instr,err}", e.addr),
                    64'({rsp_addr, rsp_instr, rsp_err}), 64'({e.addr, e.instr, e.err}));
                if (e.lat)
                    chk($sformatf("latency addr=%0d cycle", e.addr), 64'(cyc), 64'(e.acc_cyc));
            end
        end
    end

    // Presents one request until accepted, then records what should come back.
    task automatic issue(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] ins,
                         input logic e, input bit lat);
        int n;
        exp_t x;
        n = 0;
        req_valid = 1'b1;
        req_addr  = a;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        if (n >= 20) begin
            chk("issue_timeout", 64'(n), 64'(0));
        end else begin
            x.addr = a; x.instr = ins; x.err = e; x.acc_cyc = cyc; x.lat = lat;
            sb.push_back(x);
        end
        req_valid = 1'b0;
    endtask

    task automatic load(input logic [5:0] a, input logic [DATA_W-1:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_remaining", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;

        #12;
        chk("reset rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset {instr,addr,err}", 64'({rsp_instr, rsp_addr, rsp_err}), 64'(0));
        chk("reset req_ready", 64'(req_ready), 64'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;

        load(6'd0, 32'h08000004);
        load(6'd1, 32'h02508020);
        load(6'd2, 32'h02118020);
        load(6'd3, 32'h02328020);
        load(6'd63, 32'h12345678);

        vecs[0] = '{9'd0,   32'h08000004, 1'b0};
        vecs[1] = '{9'd4,   32'h02508020, 1'b0};
        vecs[2] = '{9'd8,   32'h02118020, 1'b0};
        vecs[3] = '{9'd12,  32'h02328020, 1'b0};
        vecs[4] = '{9'd6,   32'h00000000, 1'b1};
        vecs[5] = '{9'd256, 32'h00000000, 1'b1};
        vecs[6] = '{9'd252, 32'h12345678, 1'b0};
        vecs[7] = '{9'd255, 32'h00000000, 1'b1};

        for (int i = 0; i < 8; i++)
            issue(vecs[i].addr, vecs[i].instr, vecs[i].err, 1'b1);
        drain();

        // Stall with the held word being rewritten underneath it.
        rsp_ready = 1'b0;
        issue(9'd8, 32'h02118020, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            ld_en = 1'b1; ld_addr = 6'd2; ld_data = 32'hA0000000 + k;
            @(negedge clk);
            chk($sformatf("stall%0d req_ready", k), 64'(req_ready), 64'(0));
            chk($sformatf("stall%0d {valid,instr,addr,err}", k),
                64'({rsp_valid, rsp_instr, rsp_addr, rsp_err}),
                64'({1'b1, 32'h02118020, 9'd8, 1'b0}));
            @(posedge clk);
            #1;
        end
        ld_en = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("after_stall req_ready", 64'(req_ready), 64'(1));
        chk("after_stall rsp_valid", 64'(rsp_valid), 64'(0));
        chk("after_stall sb_empty", 64'(sb.size()), 64'(0));
        @(posedge clk);
        #1;

        // Load and fetch of the same word in one cycle.
        ld_en = 1'b1; ld_addr = 6'd5; ld_data = 32'hDEADBEEF;
        issue(9'd20, 32'hDEADBEEF, 1'b0, 1'b1);
        ld_en = 1'b0;
        drain();
        issue(9'd20, 32'hDEADBEEF, 1'b0, 1'b1);
        drain();

        // Asynchronous reset while a response is held.
        rsp_ready = 1'b0;
        issue(9'd0, 32'h08000004, 1'b0, 1'b0);
        chk("pre_reset rsp_valid", 64'(rsp_valid), 64'(1));
        rst = 1'b1;
        #1;
        chk("async_reset rsp_valid", 64'(rsp_valid), 64'(0));
        chk("async_reset {instr,addr,err}", 64'({rsp_instr, rsp_addr, rsp_err}), 64'(0));
        chk("async_reset req_ready", 64'(req_ready), 64'(1));
        sb.delete();
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        issue(9'd4, 32'h02508020, 1'b0, 1'b1);
        issue(9'd8, 32'hA0000002, 1'b0, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_fetch.md
# imem_fetch

Parametrised instruction memory with a valid/ready fetch interface and a program-load port. It is the next generation of the fixed 4-entry instruction ROM: configurable width and depth, loadable at run time, with registered responses, back-pressure, and error flagging for misaligned or out-of-range fetches. It sits between the PC/fetch stage and decode.

## Interface
- DATA_W, 32, instruction width in bits; a multiple of 8.
- DEPTH, 64, number of instruction words; a power of two, ≥ 2.
- ADDR_W, 8, byte-address width of req_addr; must satisfy 2^ADDR_W ≥ DEPTH·DATA_W/8.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  block can accept a request this cycle.
- req_addr  in  ADDR_W  byte address of the instruction.
- rsp_valid  out  1  response held in the output register.
- rsp_ready  in  1  consumer takes the response this cycle.
- rsp_instr  out  DATA_W  fetched instruction; NOP (all zeros) on error.
- rsp_addr  out  ADDR_W  echo of the request address.
- rsp_err  out  1  request was misaligned or out of range.
- ld_en  in  1  write one instruction word.
- ld_addr  in  $clog2(DEPTH)  word index to write.
- ld_data  in  DATA_W  instruction to store.

## Operation
- Word index is req_addr >> log2(DATA_W/8).
- A request is misaligned if the low log2(DATA_W/8) address bits are non-zero.
- A request is out of range if its word index is ≥ DEPTH.
- Accept: req_valid && req_ready.
- req_ready = !rsp_valid || rsp_ready. This is combinational, giving a one-deep pipeline that sustains one fetch per cycle.
- On accept:
  - The output register loads instr, addr and err on the next edge, and rsp_valid goes to 1.
  - If err=1, instr is NOP and the memory array is not read.
- Consume with rsp_valid && rsp_ready and no new accept in the same cycle: rsp_valid goes to 0.
- Stall (rsp_valid && !rsp_ready): rsp_instr, rsp_addr and rsp_err stay stable, including when ld_en rewrites the word being presented.
- Load: when ld_en=1, mem[ld_addr] ← ld_data at the edge.
  - ld_addr ≥ DEPTH is ignored; this is only reachable when DEPTH is not a power of two, so it is a defensive check.
  - Loads are accepted in every cycle regardless of fetch state.
- Simultaneous load and accepted fetch of the same word: the response carries the new ld_data (write-forwarding).
- Memory contents are not affected by rst. Only pipeline state resets.

## Timing
- Reset values: rsp_valid=0, rsp_instr=0, rsp_addr=0, rsp_err=0. req_ready=1 while in and after reset.
- Reset mid-operation discards any held response immediately (asynchronous). Loads already written persist.
- Latency: request accepted at edge N gives rsp_valid=1 with data after edge N, visible during cycle N+1.
- Throughput: 1 response per cycle while rsp_ready=1.
- Back-to-back flow: consume and accept in the same cycle replace the output register with no bubble.

## Structure
- Package imem_pkg holds:
  - the NOP constant (all zeros, width DATA_W via a function or parameter),
  - the error enum ERR_NONE, ERR_MISALIGN, ERR_RANGE; internal only, the port exposes only their OR.
- Sub-module imem_array contains the storage: synchronous write port, combinational read port, DEPTH × DATA_W, no reset.
- The top level holds the alignment/range checks, forwarding mux, output register and handshake logic.

## Test plan
- Reset, load words 0..3 with 0x08000004, 0x02508020, 0x02118020, 0x02328020, then fetch addrs 0,4,8,12 with rsp_ready=1 → four consecutive responses with matching instr, err=0, one per cycle, first one cycle after its request.
- Fetch addr 6 → rsp_err=1, rsp_instr=0, rsp_addr=6. Fetch addr 4·DEPTH (256) → rsp_err=1, instr=0.
- Hold rsp_ready=0 for 3 cycles after a response while ld_en rewrites that word → req_ready=0 throughout, response fields unchanged. Then rsp_ready=1 → consumed; req_ready=1 next cycle.
- Same-cycle ld_en (ld_addr=5, ld_data=0xDEADBEEF) and fetch addr 20 → rsp_instr=0xDEADBEEF.
- Assert rst while rsp_valid=1 → rsp_* cleared immediately without waiting for clk. Re-fetch a previously loaded word → original contents returned.
